// File: rtl/pipemem_stage.sv
// MEM stage: issues loads and stores on a variable-latency req/ack bus and stalls the front of the pipe until the access finishes.
// Also registers the MEM/WB fields, inserting a bubble on every stalled cycle.
module pipemem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        mem_stall,
    output logic        merr,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        merr_q, merr_d;
    logic        wwreg_q, wwreg_d;
    logic        wm2reg_q, wm2reg_d;
    logic [31:0] wmo_q, wmo_d;
    logic [31:0] walu_q, walu_d;
    logic [4:0]  wrn_q, wrn_d;

    logic memop;

    // done marks "this instruction's access has finished"; it is what releases the stall.
    assign memop     = mm2reg | mwmem;
    assign mem_stall = memop & ~done_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        state_d     = state_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        merr_d      = 1'b0;
        wwreg_d     = wwreg_q;
        wm2reg_d    = wm2reg_q;
        wmo_d       = wmo_q;
        walu_d      = walu_q;
        wrn_d       = wrn_q;

        case (state_q)
            S_IDLE: begin
                if (memop && !done_q) begin
                    state_d     = S_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mwmem;
                    bus_addr_d  = {malu[31:2], 2'b00};
                    bus_wdata_d = mb;
                    cnt_d       = 8'd0;
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    // Abandon the access: the load still writes back, with zero data.
                    rdata_d   = 32'd0;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    merr_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The FSM only sets done while stalled, so clearing it here never collides.
        if (!mem_stall) begin
            wwreg_d  = mwreg;
            wm2reg_d = mm2reg;
            walu_d   = malu;
            wrn_d    = mrn;
            wmo_d    = memop ? rdata_q : 32'd0;
            done_d   = 1'b0;
        end else begin
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
            wrn_d    = 5'd0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            cnt_q       <= 8'd0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            merr_q      <= 1'b0;
            wwreg_q     <= 1'b0;
            wm2reg_q    <= 1'b0;
            wmo_q       <= 32'd0;
            walu_q      <= 32'd0;
            wrn_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            merr_q      <= merr_d;
            wwreg_q     <= wwreg_d;
            wm2reg_q    <= wm2reg_d;
            wmo_q       <= wmo_d;
            walu_q      <= walu_d;
            wrn_q       <= wrn_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign merr      = merr_q;
    assign wwreg     = wwreg_q;
    assign wm2reg    = wm2reg_q;
    assign wmo       = wmo_q;
    assign walu      = walu_q;
    assign wrn       = wrn_q;

endmodule

// File: tb/tb_pipemem_stage.sv
// Bench for pipemem_stage: directed test-plan steps followed by random instructions,
// each judged against a per-instruction transaction model (stall length, bus fields, W result).
module tb_pipemem_stage;

    localparam int unsigned TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;
    logic        mem_stall, merr;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int checks = 0;
    int errors = 0;

    pipemem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_stall(mem_stall), .merr(merr),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present one instruction at a falling edge and follow it until it lands in W.
    // lat = cycle (counted from bus_req rising) on which ack is given; 0 = never ack.
    task automatic run_instr(input string tag, input logic wreg, input logic m2reg, input logic wmem,
                             input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                             input int lat, input logic [31:0] rd);
        logic        is_mem, is_tmo;
        int          exp_stall, stall_cnt, req_cnt, merr_cnt;
        logic [31:0] exp_wmo;
        bit          finished;

        is_mem    = m2reg | wmem;
        is_tmo    = is_mem && (lat == 0);
        exp_stall = !is_mem ? 0 : (is_tmo ? int'(TIMEOUT) + 1 : lat + 1);
        exp_wmo   = (!is_mem || is_tmo) ? 32'd0 : rd;

        mwreg = wreg; mm2reg = m2reg; mwmem = wmem; malu = alu; mb = b; mrn = rn;
        stall_cnt = 0; req_cnt = 0; merr_cnt = 0; finished = 0;

        for (int c = 0; c < 40; c++) begin
            bus_ack = 1'b0;
            #1;
            if (merr === 1'b1) merr_cnt++;
            if (mem_stall === 1'b0) begin
                finished = 1;
                break;
            end
            stall_cnt++;
            if (stall_cnt >= 2) begin
                check({tag, " bubble wwreg"}, 32'(wwreg), 32'd0);
                check({tag, " bubble wrn"}, 32'(wrn), 32'd0);
            end
            if (bus_req === 1'b1) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({tag, " bus_addr"}, bus_addr, {alu[31:2], 2'b00});
                    check({tag, " bus_we"}, 32'(bus_we), 32'(wmem));
                    if (wmem) check({tag, " bus_wdata"}, bus_wdata, b);
                end
                if (lat != 0 && req_cnt == lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd;
                end
            end
            next_cycle();
        end
        bus_ack = 1'b0;

        check({tag, " completes"}, 32'(finished), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " req cycles"}, 32'(req_cnt), 32'(is_mem ? exp_stall - 1 : 0));
        check({tag, " merr pulses"}, 32'(merr_cnt), 32'(is_tmo ? 1 : 0));
        check({tag, " bus_req idle"}, 32'(bus_req), 32'd0);

        next_cycle();
        #1;
        check({tag, " wwreg"}, 32'(wwreg), 32'(wreg));
        check({tag, " wm2reg"}, 32'(wm2reg), 32'(m2reg));
        check({tag, " walu"}, walu, alu);
        check({tag, " wrn"}, 32'(wrn), 32'(rn));
        check({tag, " wmo"}, wmo, exp_wmo);
        check({tag, " merr after"}, 32'(merr), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0; mrn = 0;
        bus_ack = 0; bus_rdata = 0;
        #3;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset wwreg", 32'(wwreg), 32'd0);
        check("reset walu", walu, 32'd0);
        check("reset merr", 32'(merr), 32'd0);
        check("reset mem_stall", 32'(mem_stall), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        next_cycle();

        // Plan steps 1-4, then a late ack after the timeout.
        run_instr("alu", 1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        run_instr("load", 1, 1, 0, 32'h0000_0043, 32'h0, 5'd9, 3, 32'hCAFE_F00D);
        run_instr("store", 0, 0, 1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 1, 32'h1357_9BDF);
        run_instr("timeout", 1, 1, 0, 32'h0000_0200, 32'h0, 5'd7, 0, 32'h0);

        mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mrn = 0;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("late ack bus_req", 32'(bus_req), 32'd0);
        check("late ack stall", 32'(mem_stall), 32'd0);
        check("late ack merr", 32'(merr), 32'd0);
        run_instr("post-late load", 1, 1, 0, 32'h0000_0300, 32'h0, 5'd4, 2, 32'h0000_5555);

        // Reset while waiting on the bus.
        run_instr("pre-reset alu", 1, 0, 0, 32'h0000_0777, 32'h0, 5'd3, 0, 32'h0);
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h0000_0100; mrn = 5'd6;
        next_cycle();
        #1;
        check("wait before reset bus_req", 32'(bus_req), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset bus_req", 32'(bus_req), 32'd0);
        check("async reset walu", walu, 32'd0);
        check("async reset wmo", wmo, 32'd0);
        check("async reset wrn", 32'(wrn), 32'd0);
        check("async reset wwreg", 32'(wwreg), 32'd0);
        mwreg = 0; mm2reg = 0; malu = 0; mrn = 0;
        @(negedge clock);
        resetn = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("idle ack bus_req", 32'(bus_req), 32'd0);
        check("idle ack stall", 32'(mem_stall), 32'd0);
        check("idle ack wmo", wmo, 32'd0);

        // Back-to-back loads.
        run_instr("b2b load0", 1, 1, 0, 32'h0000_0010, 32'h0, 5'd1, 2, 32'd1);
        run_instr("b2b load1", 1, 1, 0, 32'h0000_0014, 32'h0, 5'd2, 1, 32'd2);

        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [31:0] a, b, r;
            logic [4:0]  rn;
            sel = int'($urandom_range(0, 4));
            a   = $urandom;
            b   = $urandom;
            r   = $urandom;
            rn  = 5'($urandom);
            case (sel)
                0: run_instr("rnd nop", 0, 0, 0, a, b, rn, 0, r);
                1: run_instr("rnd alu", 1, 0, 0, a, b, rn, 0, r);
                2: run_instr("rnd load", 1, 1, 0, a, b, rn, int'($urandom_range(1, TIMEOUT)), r);
                3: run_instr("rnd store", 0, 0, 1, a, b, rn, int'($urandom_range(1, TIMEOUT)), r);
                default: run_instr("rnd timeout", 1, 1, 0, a, b, rn, 0, r);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
